rca_lsq_arbiter: RTL

Round-robin arbiter that shares the single RCA load/store queue (LSQ) port among `NUM_OUS` operation units. Each cycle it grants at most one OU request, forwarding the request's address, data, fn3 and load/store flags to the LSQ. It records the requester ID of every granted load in an in-order tag FIFO, so returning `load_complete` pulses reach the OU that issued the load. Sits between the OU array and the LSQ inside the RCA.

---
 rtl/rca_lsq_arbiter_if.sv | 33 +++
 rtl/rca_lsq_arbiter.sv | 82 ++++++++
 2 files changed

// File: rtl/rca_lsq_arbiter_if.sv
// rca_lsq_arbiter_if: OU-side and LSQ-side buses of the RCA LSQ arbiter
interface rca_lsq_arbiter_if #(
    parameter int NUM_OUS = 4,
    parameter int XLEN = 32
);
    logic [NUM_OUS-1:0][XLEN-1:0] ou_addr;
    logic [NUM_OUS-1:0][XLEN-1:0] ou_data;
    logic [NUM_OUS-1:0][2:0] ou_fn3;
    logic [NUM_OUS-1:0] ou_load;
    logic [NUM_OUS-1:0] ou_store;
    logic [NUM_OUS-1:0] ou_new_request;
    logic [NUM_OUS-1:0] ou_lsq_full;
    logic [NUM_OUS-1:0] ou_load_complete;
    logic [XLEN-1:0] ou_load_data;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [2:0] fn3;
    logic load;
    logic store;
    logic new_request;
    logic lsq_full;
    logic [XLEN-1:0] load_data;
    logic load_complete;

    modport master (
        input ou_addr, ou_data, ou_fn3, ou_load, ou_store, ou_new_request, lsq_full, load_data, load_complete,
        output ou_lsq_full, ou_load_complete, ou_load_data, addr, data, fn3, load, store, new_request
    );
    modport slave (
        output ou_addr, ou_data, ou_fn3, ou_load, ou_store, ou_new_request, lsq_full, load_data, load_complete,
        input ou_lsq_full, ou_load_complete, ou_load_data, addr, data, fn3, load, store, new_request
    );
endinterface

// File: rtl/rca_lsq_arbiter.sv
// rca_lsq_arbiter: round-robin OU arbiter for the RCA LSQ port with in-order load tag FIFO
module rca_lsq_arbiter #(
    parameter int NUM_OUS = 4,
    parameter int MAX_OUTSTANDING_LOADS = 4,
    parameter int XLEN = 32
) (
    input logic clk,
    input logic rst,
    rca_lsq_arbiter_if.master bus,
    output logic err_unexpected_complete
);
    localparam int IW = $clog2(NUM_OUS);
    localparam int FW = $clog2(MAX_OUTSTANDING_LOADS);

    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] g;
    logic [IW-1:0] idx;
    logic grant;
    logic [FW-1:0] head;
    logic [FW-1:0] tail;
    logic [FW:0] count;
    logic [IW-1:0] tags [MAX_OUTSTANDING_LOADS];
    logic fifo_full;
    logic push;
    logic pop;
    logic [NUM_OUS-1:0] eligible;

    // Loads need a free tag slot; a same-cycle pop does not count as free.
    assign fifo_full = count == (FW+1)'(MAX_OUTSTANDING_LOADS);
    assign eligible = bus.lsq_full ? '0 : bus.ou_new_request & ~(bus.ou_load & {NUM_OUS{fifo_full}});

    always_comb begin
        grant = 1'b0;
        g = '0;
        idx = '0;
        for (int k = 0; k < NUM_OUS; k++) begin
            idx = IW'((int'(rr_ptr) + k) % NUM_OUS);
            if (!grant && eligible[idx]) begin
                grant = 1'b1;
                g = idx;
            end
        end
    end

    assign push = grant && bus.ou_load[g];
    assign pop = bus.load_complete && count != '0;

    assign bus.new_request = grant;
    assign bus.addr = grant ? bus.ou_addr[g] : '0;
    assign bus.data = grant ? bus.ou_data[g] : '0;
    assign bus.fn3 = grant ? bus.ou_fn3[g] : '0;
    assign bus.load = grant && bus.ou_load[g];
    assign bus.store = grant && bus.ou_store[g];
    assign bus.ou_lsq_full = grant ? ~(NUM_OUS'(1) << g) : '1;
    assign bus.ou_load_complete = pop ? NUM_OUS'(1) << tags[head] : '0;
    assign bus.ou_load_data = bus.load_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            head <= '0;
            tail <= '0;
            count <= '0;
            err_unexpected_complete <= 1'b0;
        end else begin
            if (grant)
                rr_ptr <= g == IW'(NUM_OUS - 1) ? '0 : g + IW'(1);
            if (push)
                tail <= tail + FW'(1);
            if (pop)
                head <= head + FW'(1);
            count <= count + (FW+1)'(push) - (FW+1)'(pop);
            if (bus.load_complete && count == '0)
                err_unexpected_complete <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            tags[tail] <= g;
    end
endmodule
